audio_dac_serializer: RTL and testbench

//  Consumer end of the sample stream produced by the ROM-playback block (32-bit sound word at ~44.1 kHz).

---
 rtl/audio_pkg.sv | 8 +
 rtl/sample_fifo.sv | 49 ++++
 rtl/audio_dac_serializer.sv | 102 ++++++++++
 tb/tb_audio_dac_serializer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and FSM encoding for the I2S audio DAC serializer.
package audio_pkg;
  localparam int AUD_DATA_W     = 32;
  localparam int AUD_FIFO_DEPTH = 4;
  localparam int BIT_CNT_W      = $clog2(AUD_DATA_W);

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO; level saturates at DEPTH, pointers wrap modulo DEPTH.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int DATA_W = AUD_DATA_W,
  parameter int DEPTH  = AUD_FIFO_DEPTH,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/audio_dac_serializer.sv
// Buffers producer samples and shifts each one out on both I2S channels of a frame;
// the codec owns BCLK/LRCK, which are synchronised into CLOCK_50 here.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W      = AUD_DATA_W,
  parameter int FIFO_DEPTH  = AUD_FIFO_DEPTH,
  parameter int SYNC_STAGES = 2,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              AUD_BCLK,
  input  logic              AUD_DACLRCK,
  output logic              AUD_DACDAT,
  output logic              underrun,
  output logic [LVL_W-1:0]  fifo_level
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync;
  logic                   bclk_s, lrck_s, bclk_prev, lrck_q;
  logic                   bclk_fall, lrck_chg, frame_start;
  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W-1:0]      fifo_rd, tx_word;
  logic [CNT_W-1:0]       bit_cnt;
  state_t                 state;

  sample_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (CLOCK_50),
    .reset   (reset),
    .push    (sample_valid),
    .wr_data (sample_in),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign sample_ready = ~fifo_full;

  assign bclk_s      = bclk_sync[SYNC_STAGES-1];
  assign lrck_s      = lrck_sync[SYNC_STAGES-1];
  assign bclk_fall   = bclk_prev & ~bclk_s;
  assign lrck_chg    = bclk_fall & (lrck_s ^ lrck_q);
  assign frame_start = bclk_fall & lrck_q & ~lrck_s;
  assign fifo_pop    = frame_start & ~fifo_empty;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_prev <= 1'b0;
      lrck_q    <= 1'b0;
    end else begin
      bclk_sync <= (bclk_sync << 1) | SYNC_STAGES'(AUD_BCLK);
      lrck_sync <= (lrck_sync << 1) | SYNC_STAGES'(AUD_DACLRCK);
      bclk_prev <= bclk_s;
      if (bclk_fall) lrck_q <= lrck_s;
    end
  end

  // The MSB goes out on the fall after the delay slot; bit_cnt then indexes the next bit.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      tx_word    <= '0;
      bit_cnt    <= '0;
      AUD_DACDAT <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (frame_start) begin
        tx_word    <= fifo_empty ? '0 : fifo_rd;
        underrun   <= fifo_empty;
        state      <= DELAY;
        AUD_DACDAT <= 1'b0;
      end else if (lrck_chg && state != IDLE) begin
        state      <= DELAY;
        AUD_DACDAT <= 1'b0;
      end else if (bclk_fall) begin
        case (state)
          DELAY: begin
            state      <= SHIFT;
            AUD_DACDAT <= tx_word[DATA_W-1];
            bit_cnt    <= CNT_W'(DATA_W - 2);
          end
          SHIFT: begin
            AUD_DACDAT <= tx_word[bit_cnt];
            if (bit_cnt == '0) state <= PAD;
            else               bit_cnt <= bit_cnt - 1'b1;
          end
          default: AUD_DACDAT <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: codec model drives BCLK/LRCK, scoreboard predicts serial bits.
module tb_audio_dac_serializer;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam int HB    = 34;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          AUD_BCLK = 1'b1;
  logic          AUD_DACLRCK = 1'b0;
  logic          AUD_DACDAT;
  logic          underrun;
  logic [LW-1:0] fifo_level;

  int vectors = 0, miscompares = 0;
  int urun_cnt = 0, urun_exp = 0;
  logic [DW-1:0] q_words[$];
  bit            exp_bits[$];
  logic [DW-1:0] cur_word = '0;
  bit            active = 0;
  bit            lr_prev = 0;

  audio_dac_serializer dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_DACLRCK  (AUD_DACLRCK),
    .AUD_DACDAT   (AUD_DACDAT),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(negedge CLOCK_50) if (underrun) urun_cnt++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // I2S: slot 0 after an LRCK change is the delay bit, then MSB-first, then padding.
  function automatic bit exp_bit(input int k);
    if (!active || k == 0 || k > DW) return 1'b0;
    return cur_word[DW-k];
  endfunction

  task automatic model_reset();
    q_words.delete();
    active  = 0;
    lr_prev = 0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50); reset = 1'b1;
    @(negedge CLOCK_50); reset = 1'b0;
    model_reset();
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    bit exp_rdy;
    @(negedge CLOCK_50);
    exp_rdy = (q_words.size() < DEPTH);
    vectors++;
    if (sample_ready !== exp_rdy)
      $display("FAIL push_ready: got %0b expected %0b", sample_ready, exp_rdy);
    if (sample_ready !== exp_rdy) miscompares++;
    sample_in = w; sample_valid = 1'b1;
    if (exp_rdy) q_words.push_back(w);
    @(negedge CLOCK_50); sample_valid = 1'b0;
  endtask

  // One LRCK half of n BCLK periods (8+8 CLOCK_50 cycles each).
  task automatic half(input int n, input bit lr, input int rst_at, input bit push_start,
                      input logic [DW-1:0] pw);
    bit b;
    for (int k = 0; k < n; k++) begin
      @(negedge CLOCK_50);
      AUD_BCLK = 1'b0;
      if (k == 0) begin
        AUD_DACLRCK = lr;
        if (lr_prev && !lr) begin
          active = 1;
          if (q_words.size() > 0) cur_word = q_words.pop_front();
          else begin cur_word = '0; urun_exp++; end
        end
        lr_prev = lr;
        if (push_start) q_words.push_back(pw);
      end
      exp_bits.push_back(exp_bit(k));
      for (int c = 1; c < 8; c++) begin
        @(negedge CLOCK_50);
        if (push_start && k == 0 && c == 2) begin sample_in = pw; sample_valid = 1'b1; end
        else sample_valid = 1'b0;
      end
      @(negedge CLOCK_50);
      b = exp_bits.pop_front();
      vectors++;
      if (AUD_DACDAT !== b) begin
        miscompares++;
        $display("FAIL dacdat lr=%0b k=%0d: got %0b expected %0b", lr, k, AUD_DACDAT, b);
      end
      vectors++;
      if (int'(fifo_level) !== q_words.size()) begin
        miscompares++;
        $display("FAIL level lr=%0b k=%0d: got %0d expected %0d", lr, k, fifo_level, q_words.size());
      end
      vectors++;
      if (sample_ready !== (q_words.size() < DEPTH)) begin
        miscompares++;
        $display("FAIL ready lr=%0b k=%0d: got %0b", lr, k, sample_ready);
      end
      AUD_BCLK = 1'b1;
      if (k == rst_at) begin
        @(negedge CLOCK_50); reset = 1'b1;
        @(negedge CLOCK_50); reset = 1'b0;
        model_reset();
        vectors++;
        if (AUD_DACDAT !== 1'b0 || fifo_level !== '0) begin
          miscompares++;
          $display("FAIL mid_reset: got dacdat=%0b level=%0d expected 0/0", AUD_DACDAT, fifo_level);
        end
        repeat (5) @(negedge CLOCK_50);
      end else
        repeat (7) @(negedge CLOCK_50);
    end
  endtask

  task automatic check_underruns(input string name);
    vectors++;
    if (urun_cnt !== urun_exp) begin
      miscompares++;
      $display("FAIL %s underrun cycles: got %0d expected %0d", name, urun_cnt, urun_exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (fifo_level !== '0 || sample_ready !== 1'b1 || AUD_DACDAT !== 1'b0 || underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got level=%0d rdy=%0b dat=%0b urun=%0b expected 0/1/0/0",
               fifo_level, sample_ready, AUD_DACDAT, underrun);
    end
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic test_basic_frame();
    push_word(32'hA5A5_0F0F);
    half(HB, 1'b1, -1, 1'b0, '0);
    half(HB, 1'b0, -1, 1'b0, '0);
    half(HB, 1'b1, -1, 1'b0, '0);
    check_underruns("basic");
  endtask

  task automatic test_fill();
    bit exp_rdy;
    @(negedge CLOCK_50);
    sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample_in = 32'hC0DE_0000 + DW'(i * 32'h1111);
      exp_rdy = (q_words.size() < DEPTH);
      vectors++;
      if (sample_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL fill_ready i=%0d: got %0b expected %0b", i, sample_ready, exp_rdy);
      end
      if (exp_rdy) q_words.push_back(sample_in);
      @(negedge CLOCK_50);
    end
    sample_valid = 1'b0;
    vectors++;
    if (fifo_level !== 3'd4 || sample_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: got level=%0d rdy=%0b expected 4/0", fifo_level, sample_ready);
    end
    half(HB, 1'b0, -1, 1'b0, '0);
    half(HB, 1'b1, -1, 1'b0, '0);
    check_underruns("fill");
  endtask

  task automatic test_underrun();
    do_reset();
    repeat (4) @(negedge CLOCK_50);
    half(HB, 1'b1, -1, 1'b0, '0);
    half(HB, 1'b0, -1, 1'b0, '0);
    half(HB, 1'b1, -1, 1'b0, '0);
    check_underruns("underrun");
  endtask

  task automatic test_push_pop_same_cycle();
    push_word(32'h1357_9BDF);
    half(HB, 1'b0, -1, 1'b1, 32'h2468_ACE0);
    half(HB, 1'b1, -1, 1'b0, '0);
    half(HB, 1'b0, -1, 1'b0, '0);
    half(HB, 1'b1, -1, 1'b0, '0);
    check_underruns("push_pop");
  endtask

  task automatic test_reset_mid_shift();
    push_word(32'hFFFF_0000);
    half(HB, 1'b0, 5, 1'b0, '0);
    half(HB, 1'b1, -1, 1'b0, '0);
    push_word(32'h1234_5678);
    half(HB, 1'b0, -1, 1'b0, '0);
    half(HB, 1'b1, -1, 1'b0, '0);
    check_underruns("mid_reset");
  endtask

  task automatic test_short_half();
    push_word(32'hDEAD_BEEF);
    push_word(32'h8000_0001);
    half(20, 1'b0, -1, 1'b0, '0);
    half(HB, 1'b1, -1, 1'b0, '0);
    half(HB, 1'b0, -1, 1'b0, '0);
    half(HB, 1'b1, -1, 1'b0, '0);
    check_underruns("short_half");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_fill();
    test_underrun();
    test_push_pop_same_cycle();
    test_reset_mid_shift();
    test_short_half();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
